mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the core's instruction-fetch (IFU) and load/store (LSU) request/response ports. It accepts one request at a time from either port, arbitrates with LSU priority, and services it from an internal word-organised, byte-maskable RAM after a parameterised latency. It returns a one-cycle `respValid` pulse to the port that issued the request. It sits directly opposite the core in the SoC: each `io_*` output of the core lands on the like-named input here, and vice versa.

## Interface
- `DEPTH_WORDS`, 4096: RAM size in 32-bit words; power of two.
- `LATENCY`, 1: cycles from request acceptance to `respValid`; legal range 1..15.
- `BASE_ADDR`, 32'h8000_0000: byte address of word 0.
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `io_ifu_reqValid`  in  1: fetch request; held high with a stable address until the response.
- `io_ifu_addr`  in  32: fetch byte address.
- `io_ifu_respValid`  out  1: one-cycle fetch-response strobe.
- `io_ifu_rdata`  out  32: fetched word; valid while `io_ifu_respValid` is high.
- `io_lsu_reqValid`  in  1: load/store request; held high with stable fields until the response.
- `io_lsu_addr`  in  32: byte address.
- `io_lsu_size`  in  2: access size (0 = byte, 1 = half, 2 = word); informational only, since `wmask` governs writes.
- `io_lsu_wen`  in  1: 1 = store, 0 = load.
- `io_lsu_wdata`  in  32: store data, already lane-aligned.
- `io_lsu_wmask`  in  4: byte-lane write enables.
- `io_lsu_respValid`  out  1: one-cycle load/store-response strobe.
- `io_lsu_rdata`  out  32: aligned word for loads; 0 for stores.

## Operation
- FSM states are IDLE, WAIT and RESP.
- **IDLE**
  - If `io_lsu_reqValid` is high, accept the LSU request.
  - Otherwise, if `io_ifu_reqValid` is high, accept the IFU request.
  - Otherwise, stay in IDLE.
  - If both requests are high, LSU wins. The IFU request stays pending because the core holds it.
- **Acceptance edge**
  - Latch the owner (IFU or LSU), the word index, `wen`, `wdata` and `wmask`.
  - Load the latency counter with `LATENCY-1`.
  - Go to RESP if `LATENCY==1`, otherwise go to WAIT.
- **Store commit**
  - A store writes the lanes whose `wmask` bit is set, on the acceptance edge.
  - A store with `wmask==0` writes nothing but is still acknowledged.
- **WAIT**
  - Decrement the counter each cycle.
  - At 0, go to RESP.
- **RESP**
  - Assert the owner's `respValid` for exactly one cycle, with the registered data.
  - Go to IDLE on the next edge.
  - The non-owner's `respValid` stays 0.
- **Address decode**
  - Word index = `(addr - BASE_ADDR) >> 2`.
  - `addr[1:0]` is ignored; reads always return the full aligned word.
  - If the offset is at or beyond `DEPTH_WORDS*4`, or `addr < BASE_ADDR`, the access is out of range.
  - An out-of-range read returns `32'h0`. An out-of-range write is dropped.
  - Both out-of-range cases are still acknowledged normally.
- **Arithmetic**
  - The offset subtraction is 32-bit unsigned.
  - A wrapped (negative) result counts as out of range.
- **Back-to-back requests**
  - A `reqValid` still high in the IDLE cycle after RESP is a new request.
  - This is how a continuous fetch stream is served.
- **Reset** (asynchronous, any state)
  - FSM returns to IDLE; counter clears to 0.
  - Both `respValid` outputs go to 0 and both `rdata` outputs go to 0.
  - An in-flight request is discarded.
  - RAM contents are not cleared.
  - A store already committed on its acceptance edge stays written.

## Timing
- Request seen high in IDLE at cycle N → accepted at the end of cycle N → `respValid` high in cycle N+`LATENCY`.
- Read data is sampled from the RAM on the edge entering RESP. It therefore reflects a store committed on an earlier acceptance edge.
- Minimum period per request is `LATENCY`+1 cycles (RESP→IDLE→accept).
- `respValid` is never high on both ports in the same cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset values: `io_ifu_respValid`=0, `io_lsu_respValid`=0, `io_ifu_rdata`=0, `io_lsu_rdata`=0.

## Structure
- The shared package `mem_pkg` holds:
  - the state enum `mem_state_t` {IDLE, WAIT, RESP};
  - the owner enum `mem_owner_t` {OWN_IFU, OWN_LSU};
  - the out-of-range read value `MEM_OOR_RDATA = 32'h0`.
- Sub-module `mem_array`: synchronous single-port RAM, `DEPTH_WORDS`×32, with 4-bit byte-lane write enable and registered read. It contains no reset logic.
- `mem_responder` holds the FSM, arbiter, latency counter, address decode and output registers.

## Test plan
- **LSU store then load:** store `wdata`=32'h1122_3344, `wmask`=4'hF at 32'h8000_0010, then load the same address → store ack with `rdata`=0; load returns 32'h1122_3344. With `LATENCY`=1, `respValid` follows each accept by 1 cycle.
- **Byte-lane write:** preload 32'hAABB_CCDD, then store 32'h0000_EE00 with `wmask`=4'b0010 → a read returns 32'hAABB_EEDD.
- **Simultaneous requests:** IFU and LSU both raise `reqValid` in the same IDLE cycle → LSU responds first. IFU responds `LATENCY`+1 cycles later, and only `io_ifu_respValid` pulses.
- **Out of range:** load at 32'h7FFF_FFFC and at `BASE_ADDR+DEPTH_WORDS*4` → both return 0 with a normal ack. A store there leaves the RAM unchanged (read back word 0 and the last word).
- **Latency and back-to-back:** with `LATENCY`=4, hold `io_ifu_reqValid` high for 3 fetches → `respValid` pulses are 5 cycles apart and each lasts exactly 1 cycle.
- **Reset mid-operation:** drop `reset` to 0 in WAIT with `LATENCY`=4 → outputs go to 0 immediately and no response is issued. After release, a new load returns the previously stored data.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and decode helper for the core-facing memory responder.
// Pure declarations: no latency, no flow control.
// Out-of-range reads return MEM_OOR_RDATA.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } mem_state_t;

    typedef enum logic {
        OWN_IFU,
        OWN_LSU
    } mem_owner_t;

    localparam logic [31:0] MEM_OOR_RDATA = 32'h0;

    // off is addr - base, unsigned; a wrapped subtraction shows up as addr < base
    function automatic logic addr_oor(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] off,
                                      input logic [32:0] limit);
        return (addr < base) || ({1'b0, off} >= limit);
    endfunction

endpackage

// File: rtl/mem_array.sv
// Word-organised single-port RAM with byte-lane write enables and a registered read.
// Latency: read data appears one edge after the address; writes land on the same edge.
// No backpressure; contents are never reset.
module mem_array #(
    parameter int DEPTH_WORDS = 4096,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clock,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    wbe,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clock) begin
        for (int b = 0; b < 4; b++) begin
            if (wbe[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_responder.sv
// IFU/LSU memory responder: LSU-priority arbiter, latency counter, byte-maskable RAM.
// Latency: respValid LATENCY cycles after acceptance; one request in flight, LATENCY+1 cycles per request.
// No explicit backpressure: requesters hold reqValid until their respValid pulse.
module mem_responder
    import mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 4096,
    parameter int          LATENCY     = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_ifu_reqValid,
    input  logic [31:0] io_ifu_addr,
    output logic        io_ifu_respValid,
    output logic [31:0] io_ifu_rdata,
    input  logic        io_lsu_reqValid,
    input  logic [31:0] io_lsu_addr,
    input  logic [1:0]  io_lsu_size,
    input  logic        io_lsu_wen,
    input  logic [31:0] io_lsu_wdata,
    input  logic [3:0]  io_lsu_wmask,
    output logic        io_lsu_respValid,
    output logic [31:0] io_lsu_rdata
);

    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT    = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    mem_state_t    state;
    mem_owner_t    owner;
    logic [3:0]    cnt;
    logic [AW-1:0] idx_q;
    logic          wen_q;
    logic          oor_q;
    logic          ifu_rsp_vld;
    logic          lsu_rsp_vld;

    logic [31:0]   ifu_off;
    logic [31:0]   lsu_off;
    logic          ifu_oor;
    logic          lsu_oor;
    logic [AW-1:0] acc_idx;
    logic          acc_oor;
    logic          acc_vld;
    logic [AW-1:0] ram_addr;
    logic [3:0]    ram_wbe;
    logic [31:0]   ram_rdata;

    // Size is informational; the lane mask alone decides what a store writes.
    logic unused_size;
    assign unused_size = ^io_lsu_size;

    assign ifu_off = io_ifu_addr - BASE_ADDR;
    assign lsu_off = io_lsu_addr - BASE_ADDR;
    assign ifu_oor = addr_oor(io_ifu_addr, BASE_ADDR, ifu_off, LIMIT);
    assign lsu_oor = addr_oor(io_lsu_addr, BASE_ADDR, lsu_off, LIMIT);

    assign acc_vld = (state == IDLE) && (io_lsu_reqValid || io_ifu_reqValid);
    assign acc_idx = io_lsu_reqValid ? lsu_off[AW+1:2] : ifu_off[AW+1:2];
    assign acc_oor = io_lsu_reqValid ? lsu_oor : ifu_oor;

    // The RAM sees the incoming address while idle (store commit, and the read
    // when LATENCY==1), and the latched index afterwards for the late read.
    assign ram_addr = (state == IDLE) ? acc_idx : idx_q;
    assign ram_wbe  = (state == IDLE && io_lsu_reqValid && io_lsu_wen && !lsu_oor)
                      ? io_lsu_wmask : 4'h0;

    mem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_mem_array (
        .clock (clock),
        .addr  (ram_addr),
        .wbe   (ram_wbe),
        .wdata (io_lsu_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            owner       <= OWN_IFU;
            cnt         <= 4'd0;
            idx_q       <= '0;
            wen_q       <= 1'b0;
            oor_q       <= 1'b0;
            ifu_rsp_vld <= 1'b0;
            lsu_rsp_vld <= 1'b0;
        end else begin
            ifu_rsp_vld <= 1'b0;
            lsu_rsp_vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (acc_vld) begin
                        owner <= io_lsu_reqValid ? OWN_LSU : OWN_IFU;
                        idx_q <= acc_idx;
                        wen_q <= io_lsu_reqValid && io_lsu_wen;
                        oor_q <= acc_oor;
                        cnt   <= CNT_INIT;
                        if (LATENCY == 1) begin
                            state       <= RESP;
                            lsu_rsp_vld <= io_lsu_reqValid;
                            ifu_rsp_vld <= !io_lsu_reqValid;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state       <= RESP;
                        ifu_rsp_vld <= (owner == OWN_IFU);
                        lsu_rsp_vld <= (owner == OWN_LSU);
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Data is gated by registered flags only, so it reads 0 outside the pulse.
    assign io_ifu_respValid = ifu_rsp_vld;
    assign io_lsu_respValid = lsu_rsp_vld;
    assign io_ifu_rdata     = (ifu_rsp_vld && !oor_q) ? ram_rdata : MEM_OOR_RDATA;
    assign io_lsu_rdata     = (lsu_rsp_vld && !oor_q && !wen_q) ? ram_rdata : MEM_OOR_RDATA;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: two instances (LATENCY 1 and 4) driven by a core-like requester.
module tb_mem_responder;

    localparam int          DEPTH = 4096;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam logic [31:0] TOP   = BASE + DEPTH * 4;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst_n;
    logic        ifu_req   [2];
    logic [31:0] ifu_addr  [2];
    logic        ifu_rv    [2];
    logic [31:0] ifu_rd    [2];
    logic        lsu_req   [2];
    logic [31:0] lsu_addr  [2];
    logic [1:0]  lsu_size  [2];
    logic        lsu_wen   [2];
    logic [31:0] lsu_wdata [2];
    logic [3:0]  lsu_wmask [2];
    logic        lsu_rv    [2];
    logic [31:0] lsu_rd    [2];

    mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1), .BASE_ADDR(BASE)) dut1 (
        .clock(clock), .reset(rst_n),
        .io_ifu_reqValid(ifu_req[0]), .io_ifu_addr(ifu_addr[0]),
        .io_ifu_respValid(ifu_rv[0]), .io_ifu_rdata(ifu_rd[0]),
        .io_lsu_reqValid(lsu_req[0]), .io_lsu_addr(lsu_addr[0]), .io_lsu_size(lsu_size[0]),
        .io_lsu_wen(lsu_wen[0]), .io_lsu_wdata(lsu_wdata[0]), .io_lsu_wmask(lsu_wmask[0]),
        .io_lsu_respValid(lsu_rv[0]), .io_lsu_rdata(lsu_rd[0])
    );

    mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(4), .BASE_ADDR(BASE)) dut4 (
        .clock(clock), .reset(rst_n),
        .io_ifu_reqValid(ifu_req[1]), .io_ifu_addr(ifu_addr[1]),
        .io_ifu_respValid(ifu_rv[1]), .io_ifu_rdata(ifu_rd[1]),
        .io_lsu_reqValid(lsu_req[1]), .io_lsu_addr(lsu_addr[1]), .io_lsu_size(lsu_size[1]),
        .io_lsu_wen(lsu_wen[1]), .io_lsu_wdata(lsu_wdata[1]), .io_lsu_wmask(lsu_wmask[1]),
        .io_lsu_respValid(lsu_rv[1]), .io_lsu_rdata(lsu_rd[1])
    );

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- reference model ----------------
    logic [31:0] mdl [int];

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    function automatic bit in_range(input logic [31:0] a);
        longint off;
        off = longint'(a) - longint'(BASE);
        return (off >= 0) && (off < longint'(DEPTH) * 4);
    endfunction

    function automatic int mkey(input int d, input logic [31:0] a);
        return d * DEPTH + int'((a - BASE) >> 2);
    endfunction

    function automatic logic [31:0] mdl_read(input int d, input logic [31:0] a);
        if (!in_range(a)) return 32'h0;
        if (!mdl.exists(mkey(d, a))) return 32'h0;
        return mdl[mkey(d, a)];
    endfunction

    function automatic void mdl_write(input int d, input logic [31:0] a,
                                      input logic [31:0] wd, input logic [3:0] wm);
        logic [31:0] w;
        if (!in_range(a)) return;
        w = mdl_read(d, a);
        for (int b = 0; b < 4; b++) if (wm[b]) w[8*b +: 8] = wd[8*b +: 8];
        mdl[mkey(d, a)] = w;
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t q_ifu0[$], q_lsu0[$], q_ifu1[$], q_lsu1[$];

    task automatic push(input int d, input bit lsu, input logic [31:0] data, input int c);
        exp_t e;
        e.data = data;
        e.cyc  = c;
        if (d == 0 && !lsu) q_ifu0.push_back(e);
        if (d == 0 &&  lsu) q_lsu0.push_back(e);
        if (d == 1 && !lsu) q_ifu1.push_back(e);
        if (d == 1 &&  lsu) q_lsu1.push_back(e);
    endtask

    task automatic sb_check(input int d, input bit lsu, input logic [31:0] rd);
        exp_t e;
        bit   got = 1'b0;
        string tag;
        tag = $sformatf("d%0d_%s", d, lsu ? "lsu" : "ifu");
        if (d == 0 && !lsu && q_ifu0.size() > 0) begin e = q_ifu0.pop_front(); got = 1'b1; end
        if (d == 0 &&  lsu && q_lsu0.size() > 0) begin e = q_lsu0.pop_front(); got = 1'b1; end
        if (d == 1 && !lsu && q_ifu1.size() > 0) begin e = q_ifu1.pop_front(); got = 1'b1; end
        if (d == 1 &&  lsu && q_lsu1.size() > 0) begin e = q_lsu1.pop_front(); got = 1'b1; end
        chk({tag, "_resp_expected"}, 32'(got), 32'd1);
        if (got) begin
            chk({tag, "_rdata"}, rd, e.data);
            chk({tag, "_resp_cycle"}, 32'(cyc), 32'(e.cyc));
        end
    endtask

    always @(negedge clock) begin
        if (rst_n === 1'b1) begin
            for (int d = 0; d < 2; d++) begin
                if (ifu_rv[d] || lsu_rv[d])
                    chk($sformatf("d%0d_resp_onehot", d), 32'(ifu_rv[d]) + 32'(lsu_rv[d]), 32'd1);
                if (ifu_rv[d]) sb_check(d, 1'b0, ifu_rd[d]);
                if (lsu_rv[d]) sb_check(d, 1'b1, lsu_rd[d]);
            end
        end
    end

    // ---------------- requester tasks (entered #1 after a rising edge) ----------------
    task automatic wait_rv(input int d, input bit lsu);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clock);
            seen = lsu ? lsu_rv[d] : ifu_rv[d];
        end
        chk($sformatf("d%0d_%s_resp_seen", d, lsu ? "lsu" : "ifu"), 32'(seen), 32'd1);
        @(posedge clock);
        #1;
    endtask

    task automatic set_lsu(input int d, input bit wen, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] wm);
        lsu_req[d]   = 1'b1;
        lsu_addr[d]  = a;
        lsu_wen[d]   = wen;
        lsu_wdata[d] = wd;
        lsu_wmask[d] = wm;
        lsu_size[d]  = 2'($urandom_range(0, 2));
    endtask

    task automatic lsu_op(input int d, input bit wen, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] wm);
        set_lsu(d, wen, a, wd, wm);
        if (wen) begin
            mdl_write(d, a, wd, wm);
            push(d, 1'b1, 32'h0, cyc + lat(d));
        end else begin
            push(d, 1'b1, mdl_read(d, a), cyc + lat(d));
        end
        wait_rv(d, 1'b1);
        lsu_req[d] = 1'b0;
    endtask

    task automatic ifu_op(input int d, input logic [31:0] a);
        ifu_req[d]  = 1'b1;
        ifu_addr[d] = a;
        push(d, 1'b0, mdl_read(d, a), cyc + lat(d));
        wait_rv(d, 1'b0);
        ifu_req[d] = 1'b0;
    endtask

    // Both ports raised together: LSU served first, IFU one full period later.
    task automatic both_op(input int d, input logic [31:0] ia, input bit wen,
                           input logic [31:0] la, input logic [31:0] wd, input logic [3:0] wm);
        ifu_req[d]  = 1'b1;
        ifu_addr[d] = ia;
        set_lsu(d, wen, la, wd, wm);
        if (wen) begin
            mdl_write(d, la, wd, wm);
            push(d, 1'b1, 32'h0, cyc + lat(d));
        end else begin
            push(d, 1'b1, mdl_read(d, la), cyc + lat(d));
        end
        push(d, 1'b0, mdl_read(d, ia), cyc + 2 * lat(d) + 1);
        wait_rv(d, 1'b1);
        lsu_req[d] = 1'b0;
        wait_rv(d, 1'b0);
        ifu_req[d] = 1'b0;
    endtask

    function automatic logic [31:0] pool_addr();
        int p;
        p = $urandom_range(0, 15);
        if (p == 15) p = DEPTH - 1;
        return BASE + 32'(p) * 4 + 32'($urandom_range(0, 3));
    endfunction

    function automatic logic [31:0] rnd_addr();
        case ($urandom_range(0, 9))
            0:       return BASE - 32'(4 * $urandom_range(1, 100));
            1:       return TOP + 32'(4 * $urandom_range(0, 100));
            2:       return 32'hFFFF_FFFC;
            default: return pool_addr();
        endcase
    endfunction

    task automatic check_outputs_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_d%0d_ifu_rv", tag, d), 32'(ifu_rv[d]), 32'd0);
            chk($sformatf("%s_d%0d_lsu_rv", tag, d), 32'(lsu_rv[d]), 32'd0);
            chk($sformatf("%s_d%0d_ifu_rd", tag, d), ifu_rd[d], 32'd0);
            chk($sformatf("%s_d%0d_lsu_rd", tag, d), lsu_rd[d], 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            ifu_req[d] = 1'b0; ifu_addr[d] = '0;
            lsu_req[d] = 1'b0; lsu_addr[d] = '0; lsu_size[d] = '0;
            lsu_wen[d] = 1'b0; lsu_wdata[d] = '0; lsu_wmask[d] = '0;
        end
        repeat (3) @(posedge clock);
        #1;
        check_outputs_zero("reset");
        @(negedge clock);
        rst_n = 1'b1;
        @(posedge clock);
        #1;

        for (int d = 0; d < 2; d++) begin
            lsu_op(d, 1'b1, BASE + 32'h10, 32'h1122_3344, 4'hF);
            lsu_op(d, 1'b0, BASE + 32'h10, 32'h0, 4'h0);
            lsu_op(d, 1'b1, BASE + 32'h20, 32'hAABB_CCDD, 4'hF);
            lsu_op(d, 1'b1, BASE + 32'h20, 32'h0000_EE00, 4'b0010);
            lsu_op(d, 1'b0, BASE + 32'h22, 32'h0, 4'h0);
            lsu_op(d, 1'b1, BASE + 32'h20, 32'hFFFF_FFFF, 4'h0);
            ifu_op(d, BASE + 32'h21);
            lsu_op(d, 1'b1, BASE, 32'h0BAD_0000, 4'hF);
            lsu_op(d, 1'b1, TOP - 32'd4, 32'h0BAD_FFFF, 4'hF);
            lsu_op(d, 1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0);
            lsu_op(d, 1'b0, TOP, 32'h0, 4'h0);
            ifu_op(d, 32'h7FFF_FFFC);
            lsu_op(d, 1'b1, 32'h7FFF_FFFC, 32'hDEAD_BEEF, 4'hF);
            lsu_op(d, 1'b1, TOP, 32'hDEAD_BEEF, 4'hF);
            lsu_op(d, 1'b1, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 4'hF);
            lsu_op(d, 1'b0, BASE, 32'h0, 4'h0);
            ifu_op(d, TOP - 32'd4);
            both_op(d, BASE + 32'h10, 1'b1, BASE + 32'h10, 32'h5566_7788, 4'hF);
            ifu_op(d, BASE + 32'h10);
            ifu_op(d, BASE + 32'h20);
            ifu_op(d, BASE);
        end

        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 16; p++)
                lsu_op(d, 1'b1, BASE + 32'((p == 15) ? DEPTH - 1 : p) * 4, $urandom, 4'hF);
            repeat (150) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3: lsu_op(d, 1'b0, rnd_addr(), $urandom, 4'($urandom));
                    4, 5, 6:    lsu_op(d, 1'b1, rnd_addr(), $urandom, 4'($urandom));
                    7, 8:       ifu_op(d, rnd_addr());
                    default:    both_op(d, rnd_addr(), 1'($urandom), rnd_addr(), $urandom, 4'($urandom));
                endcase
            end
        end

        // Reset while the LATENCY=4 instance waits and the LATENCY=1 instance responds.
        lsu_op(1, 1'b1, BASE + 32'h40, 32'hCAFE_F00D, 4'hF);
        lsu_op(0, 1'b1, BASE + 32'h40, 32'h1234_5678, 4'hF);
        set_lsu(1, 1'b0, BASE + 32'h40, 32'h0, 4'h0);
        ifu_req[0]  = 1'b1;
        ifu_addr[0] = BASE + 32'h40;
        push(0, 1'b0, mdl_read(0, BASE + 32'h40), cyc + 1);
        @(negedge clock);
        @(negedge clock);
        #1;
        chk("pre_reset_d0_ifu_rv", 32'(ifu_rv[0]), 32'd1);
        rst_n      = 1'b0;
        ifu_req[0] = 1'b0;
        lsu_req[1] = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        repeat (2) @(posedge clock);
        @(negedge clock);
        rst_n = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        lsu_op(1, 1'b0, BASE + 32'h40, 32'h0, 4'h0);
        ifu_op(1, BASE + 32'h40);
        lsu_op(0, 1'b0, BASE + 32'h40, 32'h0, 4'h0);

        repeat (3) @(posedge clock);
        chk("queues_drained", 32'(q_ifu0.size() + q_lsu0.size() + q_ifu1.size() + q_lsu1.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
